carry_lookahead_adder: RTL and testbench

- Parameterised N-bit two-operand adder built as a hierarchical carry-lookahead adder: 4-bit lookahead groups plus a group-level lookahead carry unit.
- Computes {cout, sum} = a + b + cin.
- Inputs are sampled combinationally; the result is captured in output registers.
- Used as a datapath arithmetic primitive wherever a fast, registered N-bit add with carry-in/carry-out is needed.

---
 rtl/carry_lookahead_adder.sv | 97 +++++++++
 tb/tb_carry_lookahead_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/carry_lookahead_adder.sv
// Registered N-bit carry-lookahead adder: {cout, sum} = a + b + cin, one cycle of latency.
// 4-bit lookahead groups, flat group lookahead within super-groups of 4 groups.
module carry_lookahead_adder #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int NG = N / 4;
   localparam int NS = (NG + 3) / 4;

   if (N < 4 || (N % 4) != 0) begin : g_bad_width
      $error("carry_lookahead_adder: N must be a multiple of 4 and at least 4");
   end

   logic [N-1:0]  g;
   logic [N-1:0]  p;
   logic [N-1:0]  c;
   logic [N-1:0]  sum_comb;
   logic [NG-1:0] gg;
   logic [NG-1:0] gp;
   logic [NG:0]   gc;
   logic [NS:0]   sc;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      gg = '0;
      gp = '0;
      gc = '0;
      sc = '0;
      c  = '0;

      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end

      // Each super-group resolves its group carries as flat sum-of-products from its
      // carry-in; only the super-group carries ripple. For N<=16 there is one super-group.
      sc[0] = cin;
      gc[0] = cin;
      for (int s = 0; s < NS; s++) begin
         int base;
         int top;
         base = 4 * s;
         top  = (base + 3 < NG - 1) ? base + 3 : NG - 1;
         for (int j = base; j <= top; j++) begin
            logic acc;
            logic prod;
            acc = 1'b0;
            for (int t = base; t <= j; t++) begin
               prod = gg[t];
               for (int u = t + 1; u <= j; u++) prod = prod & gp[u];
               acc = acc | prod;
            end
            prod = sc[s];
            for (int u = base; u <= j; u++) prod = prod & gp[u];
            gc[j+1] = acc | prod;
         end
         sc[s+1] = gc[top+1];
      end

      for (int j = 0; j < NG; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                  | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                  | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
   end

   assign sum_comb = p ^ c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= sum_comb;
         cout <= gc[NG];
      end
   end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench: directed cases, exhaustive N=4, random N=16/N=32, against a + b + cin.
module tb_carry_lookahead_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        cin16 = 1'b0, cout16;
   logic [3:0]  a4 = '0, b4 = '0, sum4;
   logic        cin4 = 1'b0, cout4;
   logic [31:0] a32 = '0, b32 = '0, sum32;
   logic        cin32 = 1'b0, cout32;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   carry_lookahead_adder #(.N(16)) dut16 (
      .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16)
   );
   carry_lookahead_adder #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4)
   );
   carry_lookahead_adder #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .sum(sum32), .cout(cout32)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [16:0] res;
      string       name;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_table(input vec_t tbl[$]);
      foreach (tbl[i]) begin
         a16 = tbl[i].a; b16 = tbl[i].b; cin16 = tbl[i].cin;
         step();
         vectors++;
         if ({cout16, sum16} !== tbl[i].res) begin
            miscompares++;
            $display("FAIL %s: got cout/sum %b/%h, want %b/%h", tbl[i].name,
                     cout16, sum16, tbl[i].res[16], tbl[i].res[15:0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0;
      #1;
      vectors++;
      if ({cout16, sum16} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_initial: got %b/%h, want 0/0000", cout16, sum16);
      end
      step();
      vectors++;
      if ({cout16, sum16} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_held_over_edge: got %b/%h, want 0/0000", cout16, sum16);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({cout16, sum16} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_release_before_edge: got %b/%h, want 0/0000", cout16, sum16);
      end
      step();
      vectors++;
      if ({cout16, sum16} !== {1'b0, 16'h2345}) begin
         miscompares++;
         $display("FAIL first_after_reset: got %b/%h, want 0/2345", cout16, sum16);
      end
      // Asynchronous assertion while a nonzero result is held.
      a16 = 16'h1111; b16 = 16'h1111;
      step();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({cout16, sum16} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_async_midcycle: got %b/%h, want 0/0000", cout16, sum16);
      end
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1111; rst = 1'b0;
      step();
      vectors++;
      if ({cout16, sum16} !== {1'b0, 16'h2345}) begin
         miscompares++;
         $display("FAIL after_midcycle_reset: got %b/%h, want 0/2345", cout16, sum16);
      end
   endtask

   task automatic test_basic();
      vec_t t[$];
      t.push_back('{16'h00FF, 16'h0001, 1'b0, 17'h00100, "basic_ff_plus_1"});
      t.push_back('{16'h8000, 16'h8000, 1'b0, 17'h10000, "basic_msb_carry"});
      t.push_back('{16'h0000, 16'h0000, 1'b0, 17'h00000, "basic_zero"});
      run_table(t);
   endtask

   task automatic test_propagate();
      vec_t t[$];
      t.push_back('{16'hFFFF, 16'h0000, 1'b1, 17'h10000, "full_propagate"});
      t.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "all_ones_plus_cin"});
      run_table(t);
   endtask

   task automatic test_back_to_back();
      vec_t t[$];
      t.push_back('{16'h0003, 16'h0004, 1'b0, 17'h00007, "b2b_3_plus_4"});
      t.push_back('{16'hFFFE, 16'h0001, 1'b0, 17'h0FFFF, "b2b_fffe_plus_1"});
      t.push_back('{16'hAAAA, 16'h5555, 1'b1, 17'h10000, "b2b_aaaa_5555_cin"});
      run_table(t);
   endtask

   task automatic test_group_boundaries();
      vec_t t[$];
      t.push_back('{16'h000F, 16'h0001, 1'b0, 17'h00010, "group_cross_1"});
      t.push_back('{16'h0FFF, 16'h0001, 1'b0, 17'h01000, "group_cross_3"});
      t.push_back('{16'h00F0, 16'h0010, 1'b0, 17'h00100, "group_cross_mid"});
      run_table(t);
   endtask

   task automatic test_exhaustive_n4();
      for (int i = 0; i < 512; i++) begin
         logic [4:0] expected;
         a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
         expected = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
         step();
         vectors++;
         if ({cout4, sum4} !== expected) begin
            miscompares++;
            $display("FAIL exhaustive_n4 a=%h b=%h cin=%b: got %b/%h, want %b/%h",
                     a4, b4, cin4, cout4, sum4, expected[4], expected[3:0]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20000; i++) begin
         logic [16:0] exp16;
         logic [32:0] exp32;
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
         a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
         // Bias some vectors toward long carry chains.
         if (i % 8 == 0) b16 = ~a16;
         if (i % 8 == 1) b32 = ~a32;
         exp16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin16};
         exp32 = {1'b0, a32} + {1'b0, b32} + {32'b0, cin32};
         step();
         vectors++;
         if ({cout16, sum16} !== exp16) begin
            miscompares++;
            $display("FAIL random_n16 a=%h b=%h cin=%b: got %b/%h, want %b/%h",
                     a16, b16, cin16, cout16, sum16, exp16[16], exp16[15:0]);
         end
         vectors++;
         if ({cout32, sum32} !== exp32) begin
            miscompares++;
            $display("FAIL random_n32 a=%h b=%h cin=%b: got %b/%h, want %b/%h",
                     a32, b32, cin32, cout32, sum32, exp32[32], exp32[31:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_propagate();
      test_back_to_back();
      test_group_boundaries();
      test_exhaustive_n4();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
